// File: rtl/tt_check_pkg.sv
// ============================================================================
// Module : tt_check_pkg
// Brief  : Shared state type and width helper for truth_table_checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tt_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } tt_state_t;

    // Bits needed to hold the value n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module : truth_table_checker
// Brief  : Sweeps every input vector of a small combinational DUT, samples
//          its 1-bit response after a settle time and checks it against a
//          parameterised truth table. Define TT_CAPTURE_EN to keep the
//          observed truth table on obs_vec.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                 N_IN          = 2,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [2**N_IN-1:0] EXPECT        = 4'b1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   obs_vec
);

    localparam int              c_cnt_w    = cnt_w(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] c_last_vec = {N_IN{1'b1}};

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("truth_table_checker: SETTLE_CYCLES must be >= 1");
    end

    tt_state_t          r_state;
    tt_state_t          w_next;
    logic [N_IN-1:0]    r_vec;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_mismatch;
    logic [N_IN:0]      w_err_nxt;
    logic               w_restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRIVE;
            DRIVE:   w_next = SETTLE;
            SETTLE:  if (r_cnt == '0) w_next = SAMPLE;
            SAMPLE:  w_next = (r_vec == c_last_vec) ? DONE : DRIVE;
            DONE:    if (start) w_next = DRIVE;
            default: w_next = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so the registered copies
    // line up with the state register.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next)
            DRIVE, SETTLE, SAMPLE: w_busy_nxt = 1'b1;
            DONE:                  w_done_nxt = 1'b1;
            default:               ;
        endcase
    end

    assign w_mismatch = (dut_out != EXPECT[r_vec]);
    assign w_err_nxt  = err_cnt + (N_IN+1)'(w_mismatch);
    assign w_restart  = start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec      <= '0;
            r_cnt      <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            case (r_state)
                IDLE, DONE: begin
                    if (w_restart) begin
                        r_vec      <= '0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    stim  <= r_vec;
                    r_cnt <= c_cnt_w'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        err_cnt <= w_err_nxt;
                        if (err_cnt == '0) begin
                            first_fail <= r_vec;
                        end
                    end
                    if (r_vec == c_last_vec) begin
                        pass <= (w_err_nxt == '0);
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TT_CAPTURE_EN
    logic [2**N_IN-1:0] r_obs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_obs <= '0;
        end else if (w_restart) begin
            r_obs <= '0;
        end else if (r_state == SAMPLE) begin
            r_obs[r_vec] <= dut_out;
        end
    end

    assign obs_vec = r_obs;
`else
    assign obs_vec = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// Module : tb_truth_table_checker
// Brief  : Randomised self-checking bench for truth_table_checker with an
//          emulated combinational DUT driven from a lookup table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

    localparam int          N_IN   = 2;
    localparam int          SETTLE = 4;
    localparam int          NV     = 2**N_IN;
    localparam int          PER    = SETTLE + 2;
    localparam int          SWEEP  = NV * PER;
    localparam logic [3:0]  EXP    = 4'b1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [N_IN-1:0]   stim;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_cnt;
    logic [N_IN-1:0]   first_fail;
    logic [NV-1:0]     obs_vec;
    logic [NV-1:0]     dut_table;

    int n_checks = 0;
    int n_errors = 0;

    assign dut_out = dut_table[stim];

    always #5 clk = ~clk;

    truth_table_checker #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE),
        .EXPECT        (EXP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stim       (stim),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail),
        .obs_vec    (obs_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_errs(input logic [NV-1:0] t);
        int e = 0;
        for (int i = 0; i < NV; i++) if (t[i] != EXP[i]) e++;
        return e;
    endfunction

    function automatic int model_first(input logic [NV-1:0] t);
        for (int i = 0; i < NV; i++) if (t[i] != EXP[i]) return i;
        return 0;
    endfunction

    function automatic logic [NV-1:0] model_obs(input logic [NV-1:0] t);
`ifdef TT_CAPTURE_EN
        return t;
`else
        return '0;
`endif
    endfunction

    // One full sweep; busy_pulse >= 1 re-asserts start after that many edges.
    task automatic run_sweep(input logic [NV-1:0] tbl, input int busy_pulse);
        int n;
        dut_table = tbl;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err_cnt, 0);
        check("start_ff_clr", first_fail, 0);
        check("start_obs_clr", obs_vec, 0);
        n = 0;
        while (!done && n < SWEEP + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == busy_pulse);
            if (!done) begin
                check("sweep_busy", busy, 1);
                check("sweep_stim", stim, (n - 1) / PER);
            end
        end
        start = 1'b0;
        check("latency", n, SWEEP);
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("pass", pass, (model_errs(tbl) == 0) ? 1 : 0);
        check("err_cnt", err_cnt, model_errs(tbl));
        check("first_fail", first_fail, model_first(tbl));
        check("stim_hold", stim, NV - 1);
        check("obs_vec", obs_vec, model_obs(tbl));
        repeat (2) @(negedge clk);
        check("done_hold", done, 1);
        check("err_hold", err_cnt, model_errs(tbl));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_stim"}, stim, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_ff"}, first_fail, 0);
        check({tag, "_obs"}, obs_vec, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        dut_table = EXP;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_reset_state("reset");

        run_sweep(4'b1000, -1);
        run_sweep(4'b0000, -1);
        run_sweep(4'b0111, -1);
        run_sweep(4'b1000, 10);
        run_sweep(4'b1000, -1);

        // Abort a sweep while vector 2 is settling.
        dut_table = 4'b0111;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (2*PER + 2) @(negedge clk);
        check("mid_stim_v2", stim, 2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_reset_state("mid_rst");
        repeat (3) @(negedge clk);
        check("mid_rst_idle", busy, 0);
        run_sweep(4'b1000, -1);

        // Reset and start together: reset must win.
        @(negedge clk) begin
            rst   = 1'b1;
            start = 1'b1;
        end
        @(negedge clk) begin
            rst   = 1'b0;
            start = 1'b0;
        end
        check_reset_state("rst_start");
        @(negedge clk);
        check("rst_start_idle", busy, 0);

        for (int k = 0; k < 10; k++) begin
            run_sweep(NV'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 22)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
